// File: rtl/audio_pkg.sv
// Shared constants and types for the audio gain stage.
package audio_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned GAIN_W_DEF = 16;

  localparam logic [15:0] UNITY_GAIN = 16'h8000;

  localparam int SAT_MAX = (2 ** (DATA_W_DEF - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DATA_W_DEF - 1));

  typedef enum logic {
    HOLD,
    RAMP
  } gain_state_t;

endpackage

// File: rtl/audio_gain_stage_if.sv
// Valid/ready sample stream; master drives data/valid, slave drives ready.
interface audio_gain_stage_if
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/audio_gain_ramp.sv
// Target register, mute override and slew-limited gain ramp.
module audio_gain_ramp
  import audio_pkg::*;
#(
  parameter int unsigned GAIN_W    = GAIN_W_DEF,
  parameter int unsigned RAMP_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [GAIN_W-1:0] target_gain,
  input  logic              gain_load,
  input  logic              mute,
  output logic [GAIN_W-1:0] cur_gain,
  output logic              ramping
);

  localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

  logic [GAIN_W-1:0] target_reg;
  logic [GAIN_W-1:0] eff_target;
  logic [GAIN_W-1:0] gain_next;
  logic [GAIN_W-1:0] diff;
  logic [GAIN_W-1:0] delta;
  logic              going_up;
  gain_state_t       state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_reg <= GAIN_W'(UNITY_GAIN);
      cur_gain   <= '0;
    end else begin
      if (gain_load) target_reg <= target_gain;
      cur_gain <= gain_next;
    end
  end

  // State is decoded from cur_gain so that ramping follows mute without a cycle of lag.
  always_comb begin
    eff_target = mute ? '0 : target_reg;
    state      = (cur_gain == eff_target) ? HOLD : RAMP;
    going_up   = eff_target > cur_gain;
    diff       = going_up ? (eff_target - cur_gain) : (cur_gain - eff_target);
    delta      = (diff > STEP) ? STEP : diff;
    gain_next  = cur_gain;
    ramping    = 1'b0;
    unique case (state)
      HOLD: ramping = 1'b0;
      RAMP: begin
        ramping = 1'b1;
        if (accept) gain_next = going_up ? (cur_gain + delta) : (cur_gain - delta);
      end
    endcase
  end

endmodule

// File: rtl/audio_gain_stage.sv
// Two-stage streaming gain: S1 multiplies, S2 rounds, saturates and counts clips.
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned GAIN_W    = GAIN_W_DEF,
  parameter int unsigned RAMP_STEP = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  audio_gain_stage_if.slave   in_bus,
  audio_gain_stage_if.master  out_bus,
  input  logic [GAIN_W-1:0]   target_gain,
  input  logic                gain_load,
  input  logic                mute,
  output logic [GAIN_W-1:0]   cur_gain,
  output logic                ramping,
  output logic [15:0]         clip_count,
  input  logic                clip_clear
);

  localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
  localparam logic signed [PROD_W-1:0] ROUND_ADD = PROD_W'(1) <<< (GAIN_W - 2);
  localparam logic signed [PROD_W-1:0] SAT_HI    = PROD_W'(SAT_MAX);
  localparam logic signed [PROD_W-1:0] SAT_LO    = PROD_W'(SAT_MIN);

  logic                     s1_valid;
  logic                     s2_valid;
  logic                     s1_adv;
  logic                     accept;
  logic                     clip;
  logic signed [PROD_W-1:0] s1_prod;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rounded;
  logic [DATA_W-1:0]        s2_data;
  logic [DATA_W-1:0]        sat_data;

  assign s1_adv        = !s2_valid | out_bus.ready;
  assign in_bus.ready  = !s1_valid | s1_adv;
  assign accept        = in_bus.valid & in_bus.ready;
  assign out_bus.valid = s2_valid;
  assign out_bus.data  = s2_data;

  audio_gain_ramp #(
    .GAIN_W    (GAIN_W),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp (
    .clk         (clk_clk),
    .rst         (reset_reset),
    .accept      (accept),
    .target_gain (target_gain),
    .gain_load   (gain_load),
    .mute        (mute),
    .cur_gain    (cur_gain),
    .ramping     (ramping)
  );

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    prod     = PROD_W'($signed(in_bus.data)) * PROD_W'($signed({1'b0, cur_gain}));
    rounded  = (s1_prod + ROUND_ADD) >>> (GAIN_W - 1);
    clip     = 1'b0;
    sat_data = rounded[DATA_W-1:0];
    if (rounded > SAT_HI) begin
      clip     = 1'b1;
      sat_data = SAT_HI[DATA_W-1:0];
    end else if (rounded < SAT_LO) begin
      clip     = 1'b1;
      sat_data = SAT_LO[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      s1_valid   <= 1'b0;
      s1_prod    <= '0;
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      clip_count <= '0;
    end else begin
      if (in_bus.ready) begin
        s1_valid <= in_bus.valid;
        if (accept) s1_prod <= prod;
      end
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= sat_data;
      end
      if (clip_clear) begin
        clip_count <= '0;
      end else if (s1_adv && s1_valid && clip && !(&clip_count)) begin
        clip_count <= clip_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_audio_gain_stage.sv
// Scoreboard bench for audio_gain_stage with directed vectors (RAMP_STEP = 16).
module tb_audio_gain_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] target_gain;
  logic        gain_load;
  logic        mute;
  logic [15:0] cur_gain;
  logic        ramping;
  logic [15:0] clip_count;
  logic        clip_clear;

  audio_gain_stage_if in_bus ();
  audio_gain_stage_if out_bus ();

  audio_gain_stage #(
    .DATA_W    (16),
    .GAIN_W    (16),
    .RAMP_STEP (16)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .in_bus      (in_bus),
    .out_bus     (out_bus),
    .target_gain (target_gain),
    .gain_load   (gain_load),
    .mute        (mute),
    .cur_gain    (cur_gain),
    .ramping     (ramping),
    .clip_count  (clip_count),
    .clip_clear  (clip_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          lat_chk  = 1'b1;
  bit          stall_en = 1'b0;
  int          n_acc;
  int          n_out;
  bit          stalled;
  logic [15:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_bus.ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: samples at the falling edge, checks transfers, stalls and in_ready.
  always @(negedge clk) begin
    if (rst) begin
      n_acc   = 0;
      n_out   = 0;
      stalled = 1'b0;
    end else begin
      check("in_ready", {31'd0, in_bus.ready},
            {31'd0, !((n_acc - n_out) == 2 && !out_bus.ready)});
      if (stalled) begin
        check("stall_valid", {31'd0, out_bus.valid}, 32'd1);
        check("stall_data", {16'd0, out_bus.data}, {16'd0, held});
      end
      if (out_bus.valid && out_bus.ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, required no output", out_bus.data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", {16'd0, out_bus.data}, {16'd0, e.data});
          if (lat_chk) check("latency", cyc - e.cyc, 32'd2);
        end
        n_out++;
      end
      if (in_bus.valid && in_bus.ready) n_acc++;
      stalled = out_bus.valid && !out_bus.ready;
      held    = out_bus.data;
    end
  end

  task automatic send(input logic [15:0] d, input logic [15:0] e);
    int n = 0;
    in_bus.data  = d;
    in_bus.valid = 1'b1;
    @(negedge clk);
    while (!in_bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_bus.ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0, required 1 within 100 cycles");
    end else begin
      exp_q.push_back('{data: e, cyc: cyc});
    end
    @(posedge clk);
    #1;
    in_bus.valid = 1'b0;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) send(16'h0000, 16'h0000);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_gain(input logic [15:0] g);
    target_gain = g;
    gain_load   = 1'b1;
    @(posedge clk);
    #1;
    gain_load   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    in_bus.data   = '0;
    in_bus.valid  = 1'b0;
    out_bus.ready = 1'b1;
    target_gain   = '0;
    gain_load     = 1'b0;
    mute          = 1'b0;
    clip_clear    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_bus.valid}, 32'd0);
    check("rst_out_data", {16'd0, out_bus.data}, 32'd0);
    check("rst_cur_gain", {16'd0, cur_gain}, 32'd0);
    check("rst_ramping", {31'd0, ramping}, 32'd1);
    check("rst_clip_count", {16'd0, clip_count}, 32'd0);
    rst = 1'b0;

    // Fade-in after reset: 0x0000 -> 0x8000 in 2048 steps of 16.
    zeros(1024);
    check("fadein_half", {16'd0, cur_gain}, 32'h4000);
    zeros(1023);
    check("fadein_2047_gain", {16'd0, cur_gain}, 32'h7FF0);
    check("fadein_2047_ramping", {31'd0, ramping}, 32'd1);
    zeros(1);
    check("fadein_done_gain", {16'd0, cur_gain}, 32'h8000);
    check("fadein_done_ramping", {31'd0, ramping}, 32'd0);
    drain();

    // Unity passthrough.
    load_gain(16'h8000);
    send(16'h1234, 16'h1234);
    send(16'h8000, 16'h8000);
    drain();
    check("unity_ramping", {31'd0, ramping}, 32'd0);

    // Half gain, round half toward +inf.
    load_gain(16'h4000);
    zeros(1024);
    check("half_gain", {16'd0, cur_gain}, 32'h4000);
    check("half_ramping", {31'd0, ramping}, 32'd0);
    send(16'h0003, 16'h0002);
    send(16'hFFFD, 16'hFFFF);
    drain();
    check("half_clip_count", {16'd0, clip_count}, 32'd0);

    // Max gain, saturation both ways, clip counting and clear.
    load_gain(16'hFFFF);
    zeros(3071);
    check("max_ramp_gain", {16'd0, cur_gain}, 32'hFFF0);
    check("max_ramp_ramping", {31'd0, ramping}, 32'd1);
    zeros(1);
    check("max_gain", {16'd0, cur_gain}, 32'hFFFF);
    send(16'h7000, 16'h7FFF);
    send(16'h8000, 16'h8000);
    drain();
    check("clip_count_2", {16'd0, clip_count}, 32'd2);
    clip_clear = 1'b1;
    @(posedge clk);
    #1;
    clip_clear = 1'b0;
    check("clip_cleared", {16'd0, clip_count}, 32'd0);

    // Back to unity, then stream 0..999 under random backpressure.
    load_gain(16'h8000);
    zeros(2048);
    check("unity_again", {16'd0, cur_gain}, 32'h8000);
    drain();
    lat_chk  = 1'b0;
    stall_en = 1'b1;
    for (int i = 0; i < 1000; i++) send(16'(i), 16'(i));
    drain();
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lat_chk = 1'b1;
    check("stream_gain_held", {16'd0, cur_gain}, 32'h8000);

    // Mute fade-out, reversal at the midpoint.
    mute = 1'b1;
    #1;
    check("mute_ramping", {31'd0, ramping}, 32'd1);
    zeros(1024);
    check("mute_half", {16'd0, cur_gain}, 32'h4000);
    mute = 1'b0;
    send(16'h4000, 16'h2000);
    check("unmute_reverse", {16'd0, cur_gain}, 32'h4010);
    zeros(1023);
    check("unmute_done_gain", {16'd0, cur_gain}, 32'h8000);
    check("unmute_done_ramping", {31'd0, ramping}, 32'd0);
    drain();

    // Asynchronous reset mid-stream.
    send(16'h0001, 16'h0001);
    send(16'h0002, 16'h0002);
    send(16'h0003, 16'h0003);
    check("pre_reset_valid", {31'd0, out_bus.valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_bus.valid}, 32'd0);
    check("async_rst_gain", {16'd0, cur_gain}, 32'd0);
    check("async_rst_ramping", {31'd0, ramping}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'h4000, 16'h0000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
